// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - rv32i definitions shared by the load/store unit
// Purpose: word geometry defaults, LSU FSM state encoding, RV32I load/store
//          funct3 codes and the request legality/alignment check.
// Ports:   none (package).
package load_store_unit_pkg;

   localparam int RV_ADDR_WIDTH = 10;
   localparam int RV_WORD_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MERGE,
      S_WR,
      S_RESP
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Illegal funct3 for the direction, or a halfword/word access that is not
   // naturally aligned. funct3[1:0] encodes the access size for every legal code.
   function automatic logic lsu_req_error(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
      logic illegal;
      logic misaligned;
      if (we)
         illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
      else
         illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                   ((funct3[1:0] == 2'b10) && (off != 2'b00));
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/halfword lane extract, extend and store merge
// Purpose: combinational lane logic for the load/store unit (little-endian).
// Ports:   funct3    - RV32I width/sign code of the latched request
//          off       - byte offset within the word (addr[1:0])
//          rword     - word read from memory
//          wdata     - low 16 bits of the store data (right-aligned)
//          load_data - extracted and sign/zero-extended load result
//          merged    - read word with the store lane replaced (SB/SH)
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rword,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (off)
         2'd0:    byte_lane = rword[7:0];
         2'd1:    byte_lane = rword[15:8];
         2'd2:    byte_lane = rword[23:16];
         default: byte_lane = rword[31:24];
      endcase
      half_lane = off[1] ? rword[31:16] : rword[15:0];

      load_data = '0;
      case (funct3)
         F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
         F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
         F3_LW:   load_data = rword;
         F3_LBU:  load_data = {24'b0, byte_lane};
         F3_LHU:  load_data = {16'b0, half_lane};
         default: load_data = '0;
      endcase

      merged = rword;
      case (funct3)
         F3_SB: begin
            case (off)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         F3_SH: begin
            if (off[1])
               merged[31:16] = wdata;
            else
               merged[15:0] = wdata;
         end
         default: merged = rword;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write stores
// Purpose: accepts one load/store at a time, talks to a word memory with
//          one-cycle read latency, and returns a one-cycle response pulse.
// Ports:   clk, rst_n           - clock (rising edge), async active-low reset
//          req_valid/req_ready  - request handshake, ready only when idle
//          req_we, req_funct3   - store flag and RV32I width/sign code
//          req_addr, req_wdata  - byte address and right-aligned store data
//          resp_valid           - one-cycle completion pulse
//          resp_rdata, resp_err - extended load data, error flag
//          memRead, memWrite    - memory strobes
//          address, data_in     - word address and write word to memory
//          data_out             - memory read word, valid the cycle after memRead
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = RV_ADDR_WIDTH,
   parameter int WORD_WIDTH = RV_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  memRead,
   output logic                  memWrite,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [WORD_WIDTH-1:0] data_in,
   input  logic [WORD_WIDTH-1:0] data_out
);

   lsu_state_t            state;
   lsu_state_t            state_next;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic [15:0]           wdata_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0] wbuf_q;
   logic [31:0]           result_q;
   logic                  err_q;

   logic                  accept;
   logic                  req_err;
   logic [31:0]           load_data;
   logic [31:0]           merged;

   assign accept  = req_valid && (state == S_IDLE);
   assign req_err = lsu_req_error(req_we, req_funct3, req_addr[1:0]);
   assign address = addr_q;
   assign data_in = wbuf_q;

   lsu_align u_align (
      .funct3    (funct3_q),
      .off       (off_q),
      .rword     (data_out),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
         wbuf_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            addr_q   <= req_addr[ADDR_WIDTH+1:2];
            // A full-word store goes straight to memory; partial stores are
            // overwritten with the merged word in MERGE.
            wbuf_q   <= req_we ? req_wdata : '0;
            result_q <= '0;
            err_q    <= req_err;
         end else if (state == S_MERGE) begin
            if (we_q)
               wbuf_q <= merged;
            else
               result_q <= load_data;
         end
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      case (state)
         S_IDLE: begin
            // state is already IDLE while reset is held; keep ready low then
            req_ready = rst_n;
            if (accept) begin
               if (req_err)
                  state_next = S_RESP;
               else if (req_we && (req_funct3 == F3_SW))
                  state_next = S_WR;
               else
                  state_next = S_RD;
            end
         end
         S_RD: begin
            memRead    = 1'b1;
            state_next = S_MERGE;
         end
         S_MERGE: begin
            state_next = we_q ? S_WR : S_RESP;
         end
         S_WR: begin
            memWrite   = 1'b1;
            state_next = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = result_q;
            resp_err   = err_q;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for the load/store unit
module tb_load_store_unit;

   localparam int AW    = 10;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = '0;
   logic [AW+1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          memRead;
   logic          memWrite;
   logic [AW-1:0] address;
   logic [31:0]   data_in;
   logic [31:0]   data_out = '0;

   logic [31:0]   mem [0:WORDS-1];
   logic [7:0]    rb  [0:4*WORDS-1];
   logic          init_req = 1'b0;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int            resp_cyc;
      logic [31:0]   rdata;
      logic          err;
      int            rd_cyc;
      int            wr_cyc;
      logic [31:0]   wr_data;
      logic [AW-1:0] wr_addr;
   } exp_t;

   exp_t sb_q[$];

   int            rd_cnt = 0;
   int            wr_cnt = 0;
   int            rd_seen = 0;
   int            wr_seen = 0;
   logic [AW-1:0] rd_adr_seen = '0;
   logic [AW-1:0] wr_adr_seen = '0;
   logic [31:0]   wr_dat_seen = '0;

   load_store_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .address    (address),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_word(input int w);
      return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
   endfunction

   // Memory with one-cycle read latency; preloaded from the reference bytes.
   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= ref_word(i);
      end else begin
         if (memWrite) mem[address] <= data_in;
         if (memRead) data_out <= mem[address];
      end
   end

   function automatic logic ref_err(input logic we, input logic [2:0] f3, input int addr);
      bit legal;
      int size;
      legal = we ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
      size  = 1 << f3[1:0];
      return !legal || ((addr % size) != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr);
      int          size;
      logic [31:0] v;
      size = 1 << f3[1:0];
      v    = '0;
      for (int i = 0; i < size; i++) v = v | (32'(rb[addr+i]) << (8*i));
      if (!f3[2] && (size < 4) && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input int addr, input logic [31:0] wd);
      int size;
      size = 1 << f3[1:0];
      for (int i = 0; i < size; i++) rb[addr+i] = wd[8*i +: 8];
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: strobe bookkeeping and scoreboard pop on every response pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         rd_cnt = 0;
         wr_cnt = 0;
      end else begin
         check("strobe_overlap", 32'(memRead && memWrite), 32'd0);
         if (memRead) begin
            rd_cnt++;
            rd_seen     = cyc;
            rd_adr_seen = address;
         end
         if (memWrite) begin
            wr_cnt++;
            wr_seen     = cyc;
            wr_adr_seen = address;
            wr_dat_seen = data_in;
         end
         if (resp_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("resp_cycle", 32'(cyc), 32'(e.resp_cyc));
               check("resp_rdata", resp_rdata, e.rdata);
               check("resp_err", 32'(resp_err), 32'(e.err));
               check("rd_count", 32'(rd_cnt), (e.rd_cyc >= 0) ? 32'd1 : 32'd0);
               if (e.rd_cyc >= 0 && rd_cnt > 0) begin
                  check("rd_cycle", 32'(rd_seen), 32'(e.rd_cyc));
                  check("rd_address", 32'(rd_adr_seen), 32'(e.wr_addr));
               end
               check("wr_count", 32'(wr_cnt), (e.wr_cyc >= 0) ? 32'd1 : 32'd0);
               if (e.wr_cyc >= 0 && wr_cnt > 0) begin
                  check("wr_cycle", 32'(wr_seen), 32'(e.wr_cyc));
                  check("wr_address", 32'(wr_adr_seen), 32'(e.wr_addr));
                  check("wr_data", wr_dat_seen, e.wr_data);
               end
            end
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("ready_wait", 32'(req_ready), 32'd1);
   endtask

   // Issue one request; the expected response is pushed before the accept
   // edge. Cycle k after the accept edge has cyc == base + k at its negedge.
   task automatic issue(input logic we, input logic [2:0] f3, input int addr,
                        input logic [31:0] wd, input logic use_const,
                        input logic [31:0] const_rdata);
      exp_t e;
      int   base;
      int   guard;
      wait_ready();
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = (AW+2)'(addr);
      req_wdata  = wd;
      base       = cyc;
      e.err      = ref_err(we, f3, addr);
      e.rdata    = '0;
      e.rd_cyc   = -1;
      e.wr_cyc   = -1;
      e.wr_data  = '0;
      e.wr_addr  = AW'(addr / 4);
      if (e.err) begin
         e.resp_cyc = base + 1;
      end else if (we) begin
         ref_store(f3, addr, wd);
         e.wr_data = ref_word(addr / 4);
         if (f3 == 3'd2) begin
            e.wr_cyc   = base + 1;
            e.resp_cyc = base + 2;
         end else begin
            e.rd_cyc   = base + 1;
            e.wr_cyc   = base + 3;
            e.resp_cyc = base + 4;
         end
      end else begin
         e.rdata    = use_const ? const_rdata : ref_load(f3, addr);
         e.rd_cyc   = base + 1;
         e.resp_cyc = base + 3;
      end
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      // Junk requests while busy must be ignored.
      guard = 0;
      while (!req_ready && guard < 20) begin
         req_valid  = 1'b1;
         req_we     = 1'($urandom);
         req_funct3 = 3'($urandom);
         req_addr   = (AW+2)'($urandom);
         req_wdata  = $urandom;
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b0;
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 4*WORDS; i++) rb[i] = 8'($urandom);
      rb[0] = 8'hF1; rb[1] = 8'h20; rb[2] = 8'h40; rb[3] = 8'h80;
      rb[4] = 8'h44; rb[5] = 8'h33; rb[6] = 8'h22; rb[7] = 8'h11;
      init_req = 1'b1;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_memread", 32'(memRead), 32'd0);
      check("reset_address", 32'(address), 32'd0);
      init_req = 1'b0;
      rst_n    = 1'b1;
      #1;
      check("ready_after_reset", 32'(req_ready), 32'd1);

      issue(1'b0, 3'b000, 0, 32'h0, 1'b1, 32'hFFFF_FFF1);
      issue(1'b0, 3'b100, 3, 32'h0, 1'b1, 32'h0000_0080);
      issue(1'b0, 3'b001, 2, 32'h0, 1'b1, 32'hFFFF_8040);
      issue(1'b0, 3'b101, 2, 32'h0, 1'b1, 32'h0000_8040);
      issue(1'b0, 3'b010, 0, 32'h0, 1'b1, 32'h8040_20F1);
      issue(1'b1, 3'b000, 5, 32'h0000_00AB, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 4, 32'h0, 1'b1, 32'h1122_AB44);
      issue(1'b1, 3'b010, 8, 32'hDEAD_BEEF, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 8, 32'h0, 1'b1, 32'hDEAD_BEEF);
      issue(1'b0, 3'b010, 6, 32'h0, 1'b0, 32'h0);
      issue(1'b0, 3'b011, 0, 32'h0, 1'b0, 32'h0);

      // SH aborted by reset while in MERGE.
      wait_ready();
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = (AW+2)'(6);
      req_wdata  = 32'h0000_5A5A;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("sh_rd_before_reset", 32'(memRead), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_resp_err", 32'(resp_err), 32'd0);
      check("abort_resp_rdata", resp_rdata, 32'd0);
      check("abort_memwrite", 32'(memWrite), 32'd0);
      check("abort_address", 32'(address), 32'd0);
      check("abort_data_in", data_in, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_ready_after_release", 32'(req_ready), 32'd1);
      repeat (6) begin
         @(negedge clk);
         #1;
         check("abort_no_memwrite", 32'(memWrite), 32'd0);
      end
      check("abort_word1_unchanged", mem[1], 32'h1122_AB44);
      @(negedge clk);
      issue(1'b0, 3'b010, 4, 32'h0, 1'b1, 32'h1122_AB44);

      for (int n = 0; n < 300; n++) begin
         issue(1'($urandom), 3'($urandom), int'($urandom_range(0, 63)), $urandom, 1'b0, 32'h0);
      end

      guard = 0;
      while (sb_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      for (int w = 0; w < 16; w++) check($sformatf("final_mem_%0d", w), mem[w], ref_word(w));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH from the rv32i definitions header; the memory word-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default `WORD_WIDTH (32); the memory word width. Only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the core presents a load or store request.
REQ-006 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3 bits: the RV32I width/sign code.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH+2 bits: the byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: the store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: the extended load data (0 for stores and errors).
REQ-013 SHALL have port resp_err, output, 1 bit: the access was misaligned or the funct3 was illegal.
REQ-014 SHALL have ports memRead and memWrite, outputs, 1 bit each: the memory strobes.
REQ-015 SHALL have port address, output, ADDR_WIDTH bits: the word address, req_addr[ADDR_WIDTH+1:2].
REQ-016 SHALL have port data_in, output, WORD_WIDTH bits: the write word to memory.
REQ-017 SHALL have port data_out, input, WORD_WIDTH bits: the memory read word, valid the cycle after memRead.

Function
REQ-018 SHALL implement the FSM states IDLE, RD, MERGE, WR and RESP.
REQ-019 SHALL assert req_ready only in IDLE, and SHALL accept (latch the request) when req_valid && req_ready.
REQ-020 On accept, SHALL go to RESP with error set when funct3 is not in {LB 000, LH 001, LW 010, LBU 100, LHU 101} for loads or not in {SB, SH, SW} for stores, or when the access is misaligned: H/HU/SH with addr[0]=1, or W with addr[1:0]!=0.
REQ-021 On accept, SHALL go from IDLE to WR for an aligned SW, and to RD otherwise.
REQ-022 In RD, SHALL assert memRead=1 with address held, then go to MERGE.
REQ-023 In MERGE (data_out valid), a load SHALL capture the extracted lane into the result register and go to RESP; SB/SH SHALL merge req_wdata into the read word at the lane and go to WR.
REQ-024 SHALL select lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; the halfword lane is addr[1].
REQ-025 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-026 In WR, SHALL assert memWrite=1 with data_in = the write buffer and address held, then go to RESP.
REQ-027 In RESP, SHALL drive resp_valid=1 for exactly one cycle with resp_rdata and resp_err, then go to IDLE. There is no response backpressure.
REQ-028 Latency from the accept edge to resp_valid SHALL be: load 3 cycles, SW 2, SB/SH 4, error 1.
REQ-029 memRead and memWrite SHALL never be 1 in the same cycle.
REQ-030 Both strobes SHALL be 0 outside RD and WR respectively.
REQ-031 address and data_in SHALL be driven from registers and held stable from accept until RESP.
REQ-032 req_valid in non-IDLE states SHALL be ignored; the request is not latched.
REQ-033 The result and error registers SHALL clear on each accept.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, clear all registers, and drive req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, memRead=0, memWrite=0, address=0, data_in=0.
REQ-035 req_ready SHALL return to 1 in the first cycle after rst_n deasserts.
REQ-036 Reset mid-transaction SHALL abort it: no subsequent memWrite, no response, and memory is unchanged unless the WR edge has already occurred.

Structure
REQ-037 The state enum and the funct3 load/store encodings SHALL live in the shared rv32i definitions package/header.
REQ-038 Lane extract/extend and merge logic SHALL be one combinational sub-module, lsu_align; the FSM and registers SHALL live in load_store_unit.

Verification
REQ-039 Word0=0x8040_20F1; LB @0x0 -> resp_rdata 0xFFFF_FFF1 at accept+3; LBU @0x3 -> 0x0000_0080.
REQ-040 LH @0x2 on word0 -> 0xFFFF_8040; LHU @0x2 -> 0x0000_8040; LW @0x0 -> 0x8040_20F1.
REQ-041 Word1=0x1122_3344; SB @0x5 data 0x0000_00AB -> memRead at +1, memWrite at +3 with data_in 0x1122_AB44 and address 1, resp at +4; word1 reads back 0x1122_AB44.
REQ-042 SW @0x8 0xDEAD_BEEF -> no memRead, memWrite at +1, resp at +2, resp_rdata 0.
REQ-043 LW @0x6, and separately funct3 011 -> resp_err=1 at +1, strobes stay 0 throughout.
REQ-044 SH @0x6 with rst_n pulsed low in MERGE -> memWrite never asserts, word1 unchanged, req_ready=1 on the first cycle after release; a check asserts memRead and memWrite are never 1 together on every cycle.
